// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl
// Frame-rate ball/score sequencer for the pong game. Once per frame tick
// (the rising edge of screenEnd) it advances the ball, resolves wall
// bounces and paddle deflections, detects goals, keeps the score, and runs
// the IDLE -> SERVE -> PLAY -> GAMEOVER sequence.
//
// Ports
//   clock      in   1   system clock
//   reset      in   1   asynchronous active-high reset
//   screenEnd  in   1   end-of-frame level from the VGA timing block
//   start      in   1   begin-game pulse, honoured in IDLE/GAMEOVER only
//   p1_yRef    in   9   paddle 1 centre y
//   p2_yRef    in   9   paddle 2 centre y
//   ball_x     out 10   ball x
//   ball_y     out  9   ball y
//   score_p1   out  4   player 1 score
//   score_p2   out  4   player 2 score
//   winner     out  3   0 none, 1 player 1, 2 player 2
//   state      out  3   0 IDLE, 1 SERVE, 2 PLAY, 3 GAMEOVER
module pong_ball_ctrl #(
    parameter int X_INIT       = 320,
    parameter int Y_INIT       = 240,
    parameter int X_LIM        = 628,
    parameter int Y_LIM        = 463,
    parameter int P1_X         = 80,
    parameter int P2_X         = 560,
    parameter int PAD_HALF_W   = 25,
    parameter int PAD_HALF_H   = 33,
    parameter int SPEED        = 1,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       screenEnd,
    input  logic       start,
    input  logic [8:0] p1_yRef,
    input  logic [8:0] p2_yRef,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [2:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_GAMEOVER = 3'd3
    } state_t;

    localparam logic signed [11:0] C_SPEED = 12'(SPEED);
    localparam logic signed [11:0] C_XLIM  = 12'(X_LIM);
    localparam logic signed [11:0] C_YLIM  = 12'(Y_LIM);
    localparam logic signed [11:0] C_P2L   = 12'(P2_X - PAD_HALF_W);
    localparam logic signed [11:0] C_P1R   = 12'(P1_X + PAD_HALF_W);
    localparam logic signed [11:0] C_HH    = 12'(PAD_HALF_H);
    localparam logic        [9:0]  C_XI    = 10'(X_INIT);
    localparam logic        [8:0]  C_YI    = 9'(Y_INIT);
    localparam logic        [7:0]  C_SF    = 8'(SERVE_FRAMES);
    localparam logic        [3:0]  C_WIN   = 4'(WIN_SCORE);

    state_t      r_state, w_state;
    logic [9:0]  r_x, w_x;
    logic [8:0]  r_y, w_y;
    logic        r_dx, w_dx;        // 1 = moving +x
    logic        r_dy, w_dy;        // 1 = moving +y
    logic [3:0]  r_s1, w_s1;
    logic [3:0]  r_s2, w_s2;
    logic [2:0]  r_win, w_win;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_se_q;
    logic        r_armed;           // low only on the first cycle after reset
    logic        w_tick;

    logic signed [11:0] w_xn, w_yn, w_d1, w_d2;
    logic               w_hit1, w_hit2;
    logic [3:0]         w_s1_inc, w_s2_inc;
    logic [7:0]         w_cnt_inc;

    // Frame tick and next-position arithmetic
    always_comb begin
        // r_armed suppresses a tick when screenEnd is already high as reset releases
        w_tick    = screenEnd & ~r_se_q & r_armed;
        w_xn      = $signed({2'b00, r_x}) + (r_dx ? C_SPEED : -C_SPEED);
        w_yn      = $signed({3'b000, r_y}) + (r_dy ? C_SPEED : -C_SPEED);
        w_d1      = w_yn - $signed({3'b000, p1_yRef});
        w_d2      = w_yn - $signed({3'b000, p2_yRef});
        // A paddle only catches the ball as it crosses the paddle face
        w_hit2    = r_dx && ($signed({2'b00, r_x}) < C_P2L) && (w_xn >= C_P2L)
                    && (w_d2 <= C_HH) && (w_d2 >= -C_HH);
        w_hit1    = !r_dx && ($signed({2'b00, r_x}) > C_P1R) && (w_xn <= C_P1R)
                    && (w_d1 <= C_HH) && (w_d1 >= -C_HH);
        w_s1_inc  = r_s1 + 4'd1;
        w_s2_inc  = r_s2 + 4'd1;
        w_cnt_inc = r_cnt + 8'd1;
    end

    // Next-state and datapath update
    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_y     = r_y;
        w_dx    = r_dx;
        w_dy    = r_dy;
        w_s1    = r_s1;
        w_s2    = r_s2;
        w_win   = r_win;
        w_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_x = C_XI;
                w_y = C_YI;
                if (start) begin
                    w_state = ST_SERVE;
                    w_cnt   = 8'd0;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SERVE: begin
                w_x = C_XI;
                w_y = C_YI;
                // A zero-length serve moves to PLAY without waiting for a tick
                if (r_cnt >= C_SF) begin
                    w_state = ST_PLAY;
                end else if (w_tick) begin
                    w_cnt = w_cnt_inc;
                    if (w_cnt_inc >= C_SF) begin
                        w_state = ST_PLAY;
                    end else begin
                        w_state = ST_SERVE;
                    end
                end else begin
                    w_state = ST_SERVE;
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    if (w_yn <= 12'sd0) begin
                        w_y  = 9'd0;
                        w_dy = 1'b1;
                    end else if (w_yn >= C_YLIM) begin
                        w_y  = C_YLIM[8:0];
                        w_dy = 1'b0;
                    end else begin
                        w_y  = w_yn[8:0];
                    end
                    if (w_hit2) begin
                        w_x  = C_P2L[9:0];
                        w_dx = 1'b0;
                    end else if (w_hit1) begin
                        w_x  = C_P1R[9:0];
                        w_dx = 1'b1;
                    end else if ((w_xn >= C_XLIM) || (w_xn <= 12'sd0)) begin
                        // Goal: wall result is discarded, ball re-served toward the conceding side
                        w_x   = C_XI;
                        w_y   = C_YI;
                        w_dy  = 1'b0;
                        w_cnt = 8'd0;
                        if (w_xn >= C_XLIM) begin
                            w_s1 = w_s1_inc;
                            w_dx = 1'b1;
                            if (w_s1_inc == C_WIN) begin
                                w_state = ST_GAMEOVER;
                                w_win   = 3'd1;
                            end else begin
                                w_state = ST_SERVE;
                            end
                        end else begin
                            w_s2 = w_s2_inc;
                            w_dx = 1'b0;
                            if (w_s2_inc == C_WIN) begin
                                w_state = ST_GAMEOVER;
                                w_win   = 3'd2;
                            end else begin
                                w_state = ST_SERVE;
                            end
                        end
                    end else begin
                        w_x = w_xn[9:0];
                    end
                end else begin
                    w_state = ST_PLAY;
                end
            end
            ST_GAMEOVER: begin
                w_x = C_XI;
                w_y = C_YI;
                if (start) begin
                    w_s1    = 4'd0;
                    w_s2    = 4'd0;
                    w_win   = 3'd0;
                    w_cnt   = 8'd0;
                    w_state = ST_SERVE;
                end else begin
                    w_state = ST_GAMEOVER;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_x     = C_XI;
                w_y     = C_YI;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_x     <= C_XI;
            r_y     <= C_YI;
            r_dx    <= 1'b1;
            r_dy    <= 1'b0;
            r_s1    <= 4'd0;
            r_s2    <= 4'd0;
            r_win   <= 3'd0;
            r_cnt   <= 8'd0;
            r_se_q  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_s1    <= w_s1;
            r_s2    <= w_s2;
            r_win   <= w_win;
            r_cnt   <= w_cnt;
            r_se_q  <= screenEnd;
            r_armed <= 1'b1;
        end
    end

    assign ball_x   = r_x;
    assign ball_y   = r_y;
    assign score_p1 = r_s1;
    assign score_p2 = r_s2;
    assign winner   = r_win;
    assign state    = r_state;

endmodule
